vga_csr_regs: RTL

- Register file that consumes the CSR bus (write/read strobes, 8-bit address, 32-bit data) and returns read data to the bus master.
- Holds the VGA controller configuration: enable, frame-buffer base, active H/V size, frame counter, vsync interrupt.
- Geometry and base registers are double-buffered: software writes a shadow copy, and the active copy updates only on vsync, so no frame is ever torn.
- Sits between the CSR master and the VGA timing/fetch logic; all logic is in the single clk domain.

---
 rtl/vga_csr_regs_pkg.sv | 25 ++
 rtl/vga_csr_regs_if.sv | 17 +
 rtl/vga_shadow_reg.sv | 47 ++++
 rtl/vga_csr_regs.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vga_csr_regs_pkg.sv
// Purpose: shared constants for the VGA CSR register file.
//   - register word indices (CTRL_IDX .. ID_IDX)
//   - CTRL / STATUS bit positions
//   - bus and geometry widths
package vga_csr_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HV_W   = 12;

    localparam logic [ADDR_W-1:0] CTRL_IDX      = 8'h00;
    localparam logic [ADDR_W-1:0] FB_BASE_IDX   = 8'h01;
    localparam logic [ADDR_W-1:0] H_ACTIVE_IDX  = 8'h02;
    localparam logic [ADDR_W-1:0] V_ACTIVE_IDX  = 8'h03;
    localparam logic [ADDR_W-1:0] STATUS_IDX    = 8'h04;
    localparam logic [ADDR_W-1:0] FRAME_CNT_IDX = 8'h05;
    localparam logic [ADDR_W-1:0] SCRATCH_IDX   = 8'h06;
    localparam logic [ADDR_W-1:0] ID_IDX        = 8'h07;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned STATUS_IRQ_BIT  = 0;
    localparam int unsigned STATUS_UPD_BIT  = 1;

endpackage

// File: rtl/vga_csr_regs_if.sv
// Purpose: CSR bus between the register master and vga_csr_regs.
//   csr_wr_data / csr_address / csr_write / csr_read : master -> slave
//   csr_rd_data                                      : slave -> master
interface vga_csr_regs_if;
    import vga_csr_pkg::*;

    logic [DATA_W-1:0] csr_wr_data;
    logic [ADDR_W-1:0] csr_address;
    logic              csr_write;
    logic              csr_read;
    logic [DATA_W-1:0] csr_rd_data;

    modport master (output csr_wr_data, csr_address, csr_write, csr_read,
                    input  csr_rd_data);
    modport slave  (input  csr_wr_data, csr_address, csr_write, csr_read,
                    output csr_rd_data);
endinterface

// File: rtl/vga_shadow_reg.sv
// Purpose: one double-buffered configuration register.
//   With VGA_CSR_SHADOW_EN defined, writes land in shadow_q and active_q
//   loads the (pre-write) shadow on vsync_pulse when load_en is high.
//   Without it, writes go straight to active_q and shadow_q mirrors it.
// Ports: clk, reset_n, wr_en, wr_data, vsync_pulse, load_en -> shadow_q, active_q
module vga_shadow_reg #(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             vsync_pulse,
    input  logic             load_en,
    output logic [WIDTH-1:0] shadow_q,
    output logic [WIDTH-1:0] active_q
);

`ifdef VGA_CSR_SHADOW_EN
    // Active copy samples the old shadow, so a same-edge write waits a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= RST_VAL;
            active_q <= RST_VAL;
        end else begin
            if (wr_en)
                shadow_q <= wr_data;
            if (vsync_pulse && load_en)
                active_q <= shadow_q;
        end
    end
`else
    logic unused_sync_inputs;
    assign unused_sync_inputs = ^{vsync_pulse, load_en};

    // Unshadowed build: direct write, no second flop set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            active_q <= RST_VAL;
        else if (wr_en)
            active_q <= wr_data;
    end
    assign shadow_q = active_q;
`endif

endmodule

// File: rtl/vga_csr_regs.sv
// Purpose: VGA controller CSR block: CTRL, double-buffered FB_BASE/H/V
//   geometry, STATUS (W1C irq, update_pending), FRAME_CNT, SCRATCH, ID.
// Ports: clk, reset_n, csr (vga_csr_regs_if.slave), vsync_pulse ->
//   vga_enable, fb_base, h_active, v_active, irq.
// Build option: VGA_CSR_SHADOW_EN enables shadowing of indices 0x01-0x03.
module vga_csr_regs
    import vga_csr_pkg::*;
#(
    parameter logic [DATA_W-1:0] ID_VALUE     = 32'h5647_4131,
    parameter logic [HV_W-1:0]   H_ACTIVE_RST = 12'd640,
    parameter logic [HV_W-1:0]   V_ACTIVE_RST = 12'd480
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_csr_regs_if.slave     csr,
    input  logic              vsync_pulse,
    output logic              vga_enable,
    output logic [DATA_W-1:0] fb_base,
    output logic [HV_W-1:0]   h_active,
    output logic [HV_W-1:0]   v_active,
    output logic              irq
);

    logic [1:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              irq_pending_q, irq_pending_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] rd_mux;
    logic              update_pending;
    logic [DATA_W-1:0] fb_shadow;
    logic [HV_W-1:0]   h_shadow, v_shadow;
    logic              wr_fb, wr_h, wr_v, wr_geom;

    assign wr_fb   = csr.csr_write && (csr.csr_address == FB_BASE_IDX);
    assign wr_h    = csr.csr_write && (csr.csr_address == H_ACTIVE_IDX);
    assign wr_v    = csr.csr_write && (csr.csr_address == V_ACTIVE_IDX);
    assign wr_geom = wr_fb || wr_h || wr_v;

`ifdef VGA_CSR_SHADOW_EN
    logic update_pending_q;
    // A write in the vsync cycle re-arms the flag for the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            update_pending_q <= 1'b0;
        else if (wr_geom)
            update_pending_q <= 1'b1;
        else if (vsync_pulse)
            update_pending_q <= 1'b0;
    end
    assign update_pending = update_pending_q;
`else
    assign update_pending = 1'b0;
`endif

    vga_shadow_reg #(.WIDTH(DATA_W), .RST_VAL('0)) u_fb_base (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_fb), .wr_data(csr.csr_wr_data),
        .vsync_pulse(vsync_pulse), .load_en(update_pending),
        .shadow_q(fb_shadow), .active_q(fb_base));

    vga_shadow_reg #(.WIDTH(HV_W), .RST_VAL(H_ACTIVE_RST)) u_h_active (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_h), .wr_data(csr.csr_wr_data[HV_W-1:0]),
        .vsync_pulse(vsync_pulse), .load_en(update_pending),
        .shadow_q(h_shadow), .active_q(h_active));

    vga_shadow_reg #(.WIDTH(HV_W), .RST_VAL(V_ACTIVE_RST)) u_v_active (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_v), .wr_data(csr.csr_wr_data[HV_W-1:0]),
        .vsync_pulse(vsync_pulse), .load_en(update_pending),
        .shadow_q(v_shadow), .active_q(v_active));

    // Read mux over pre-write state; shadowed registers read back the shadow.
    always_comb begin
        rd_mux = '0;
        case (csr.csr_address)
            CTRL_IDX:      rd_mux = DATA_W'(ctrl_q);
            FB_BASE_IDX:   rd_mux = fb_shadow;
            H_ACTIVE_IDX:  rd_mux = DATA_W'(h_shadow);
            V_ACTIVE_IDX:  rd_mux = DATA_W'(v_shadow);
            STATUS_IDX:    rd_mux = DATA_W'({update_pending, irq_pending_q});
            FRAME_CNT_IDX: rd_mux = frame_cnt_q;
            SCRATCH_IDX:   rd_mux = scratch_q;
            ID_IDX:        rd_mux = ID_VALUE;
            default:       rd_mux = '0;
        endcase
    end

    // Next-state for the non-shadowed registers.
    always_comb begin
        ctrl_d        = ctrl_q;
        scratch_d     = scratch_q;
        frame_cnt_d   = frame_cnt_q;
        irq_pending_d = irq_pending_q;
        irq_d         = irq_pending_q && ctrl_q[CTRL_IRQ_EN_BIT];
        rd_data_d     = rd_data_q;

        if (csr.csr_read)
            rd_data_d = rd_mux;
        if (csr.csr_write && (csr.csr_address == CTRL_IDX))
            ctrl_d = csr.csr_wr_data[1:0];
        if (csr.csr_write && (csr.csr_address == SCRATCH_IDX))
            scratch_d = csr.csr_wr_data;

        // Set beats W1C when both occur together.
        if (vsync_pulse && ctrl_q[CTRL_EN_BIT]) begin
            frame_cnt_d   = frame_cnt_q + 32'd1;
            irq_pending_d = 1'b1;
        end else if (csr.csr_write && (csr.csr_address == STATUS_IDX)
                     && csr.csr_wr_data[STATUS_IRQ_BIT]) begin
            irq_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            scratch_q     <= '0;
            frame_cnt_q   <= '0;
            irq_pending_q <= 1'b0;
            irq_q         <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            scratch_q     <= scratch_d;
            frame_cnt_q   <= frame_cnt_d;
            irq_pending_q <= irq_pending_d;
            irq_q         <= irq_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign vga_enable      = ctrl_q[CTRL_EN_BIT];
    assign irq             = irq_q;
    assign csr.csr_rd_data = rd_data_q;

endmodule
